// File: rtl/otter_pc_if.sv
// Bus between the fetch/branch control logic (master) and the PC unit (slave).
interface otter_pc_if #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
);
  localparam int CW = $clog2(RAS_DEPTH + 1);

  logic            PC_STALL;
  logic            PC_LD;
  logic [XLEN-1:0] PC_DIN;
  logic            PC_PUSH;
  logic            PC_POP;
  logic            PC_ERR_CLR;
  logic [XLEN-1:0] PC_CNT;
  logic [XLEN-1:0] PC_NEXT;
  logic [CW-1:0]   RAS_COUNT;
  logic            RAS_EMPTY;
  logic            RAS_FULL;
  logic            RAS_ERR;

  modport master (
    output PC_STALL, PC_LD, PC_DIN, PC_PUSH, PC_POP, PC_ERR_CLR,
    input  PC_CNT, PC_NEXT, RAS_COUNT, RAS_EMPTY, RAS_FULL, RAS_ERR
  );

  modport slave (
    input  PC_STALL, PC_LD, PC_DIN, PC_PUSH, PC_POP, PC_ERR_CLR,
    output PC_CNT, PC_NEXT, RAS_COUNT, RAS_EMPTY, RAS_FULL, RAS_ERR
  );
endinterface

// File: rtl/otter_pc_unit.sv
// Program counter with a circular return-address stack (RAS).
// Priority: stall > pop (return) > load (jump) > sequential increment.
module otter_pc_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              INC       = 4,
  parameter int              RAS_DEPTH = 4
) (
  input  logic      PC_CLK,
  input  logic      PC_RST_N,
  otter_pc_if.slave pc_bus
);
  localparam int              CW      = $clog2(RAS_DEPTH + 1);
  localparam int              PW      = $clog2(RAS_DEPTH);
  localparam logic [XLEN-1:0] INC_C   = XLEN'(INC);
  localparam logic [CW-1:0]   DEPTH_C = CW'(RAS_DEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_next;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   top_q, top_d;
  logic            err_q, err_d;
  logic            err_set;
  logic            wr_en;
  logic [PW-1:0]   wr_idx;
  logic [XLEN-1:0] stack_q [RAS_DEPTH];

  logic ras_empty, ras_full;

  assign pc_next   = pc_q + INC_C;
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == DEPTH_C);

  // Next-state decision for PC, stack pointer/count, stack write and error flag.
  always_comb begin
    pc_d    = pc_next;
    cnt_d   = cnt_q;
    top_d   = top_q;
    err_set = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = top_q + 1'b1;
    if (pc_bus.PC_STALL) begin
      pc_d = pc_q;
    end else if (pc_bus.PC_POP) begin
      if (ras_empty) begin
        // Return with nothing on the stack: fall back to PC_DIN and flag underflow.
        pc_d    = pc_bus.PC_DIN;
        err_set = 1'b1;
        if (pc_bus.PC_PUSH) begin
          wr_en = 1'b1;
          top_d = top_q + 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        pc_d = stack_q[top_q];
        if (pc_bus.PC_PUSH) begin
          // Return-and-call: replace the top in place, depth unchanged.
          wr_en  = 1'b1;
          wr_idx = top_q;
        end else begin
          top_d = top_q - 1'b1;
          cnt_d = cnt_q - 1'b1;
        end
      end
    end else if (pc_bus.PC_LD) begin
      pc_d = pc_bus.PC_DIN;
      if (pc_bus.PC_PUSH) begin
        // Writing one past the top overwrites the oldest entry once full.
        wr_en = 1'b1;
        top_d = top_q + 1'b1;
        if (ras_full) err_set = 1'b1;
        else          cnt_d   = cnt_q + 1'b1;
      end
    end
    if (err_set)                err_d = 1'b1;
    else if (pc_bus.PC_ERR_CLR) err_d = 1'b0;
    else                        err_d = err_q;
  end

  // Control state: PC, stack pointer, entry count and sticky error flag.
  always_ff @(posedge PC_CLK or negedge PC_RST_N) begin
    if (!PC_RST_N) begin
      pc_q  <= RESET_VEC;
      cnt_q <= '0;
      top_q <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      top_q <= top_d;
      err_q <= err_d;
    end
  end

  // Stack entries hold data only and are not cleared by reset.
  always_ff @(posedge PC_CLK) begin
    if (wr_en && PC_RST_N) stack_q[wr_idx] <= pc_next;
  end

  assign pc_bus.PC_CNT    = pc_q;
  assign pc_bus.PC_NEXT   = pc_next;
  assign pc_bus.RAS_COUNT = cnt_q;
  assign pc_bus.RAS_EMPTY = ras_empty;
  assign pc_bus.RAS_FULL  = ras_full;
  assign pc_bus.RAS_ERR   = err_q;
endmodule
